pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, halt drain, perf counters
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  logic             w_stall_inc;
  logic             w_flush_inc;

  assign w_lu = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // State and drain counter register; reset drops straight back to RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Next-state and control outputs; everything is forced quiet while reset is held
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            // whole pipeline frozen, nothing counted
          end else if (ex_halt) begin
            // younger instructions are squashed; older ones keep flowing to drain
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRAIN_LOAD;
          end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_lu) begin
            // hold PC and IF/ID, insert a bubble into EX
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        ST_DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = !mem_busy;
          memwb_en   = !mem_busy;
          if (!mem_busy) begin
            if (r_drain_cnt == DRAIN_ONE) begin
              w_state_nxt = ST_HALTED;
              w_drain_nxt = '0;
            end else begin
              w_drain_nxt = r_drain_cnt - DRAIN_ONE;
            end
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
          if (resume) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_drain_nxt = '0;
        end
      endcase
    end
  end

  // Saturating performance counters; survive halt/resume, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_branch_taken;
  logic        ex_halt;
  logic        mem_busy;
  logic        resume;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [7:0]  ctl;

  int n_pass;
  int n_total;

  // ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
  localparam logic [7:0] C_IDLE   = 8'b00000_00_0;
  localparam logic [7:0] C_NORMAL = 8'b11111_00_0;
  localparam logic [7:0] C_LU     = 8'b00111_01_0;
  localparam logic [7:0] C_BRANCH = 8'b11111_11_0;
  localparam logic [7:0] C_HALT   = 8'b01111_11_0;
  localparam logic [7:0] C_DRAIN  = 8'b00011_11_0;
  localparam logic [7:0] C_DRBUSY = 8'b00000_11_0;
  localparam logic [7:0] C_HALTED = 8'b00000_00_1;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .ex_halt         (ex_halt),
    .mem_busy        (mem_busy),
    .resume          (resume),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_halt = 1'b0; mem_busy = 1'b0; resume = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    clear_in();
    ex_branch_taken = 1'b1;
    #12;
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_flush", 32'(flush_cnt), 32'd0);
    clear_in();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("normal_ctl", 32'(ctl), 32'(C_NORMAL));

    // load-use on rs2
    tick();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // load-use on rs1
    clear_in(); ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; #1;
    chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs1_stall_cnt", 32'(stall_cnt), 32'd2);

    // x0 destination never stalls
    clear_in(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk("x0_ctl", 32'(ctl), 32'(C_NORMAL));
    tick();
    chk("x0_stall_cnt", 32'(stall_cnt), 32'd2);

    // branch with simultaneous lu: branch wins
    clear_in(); ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; #1;
    chk("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

    // mem_busy freezes everything, beats lu and branch
    mem_busy = 1'b1; #1;
    chk("busy_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    chk("busy_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("busy_stall_cnt", 32'(stall_cnt), 32'd2);

    // halt at T with no busy
    clear_in(); ex_halt = 1'b1; ex_branch_taken = 1'b1; #1;
    chk("halt_T_ctl", 32'(ctl), 32'(C_HALT));
    tick();
    clear_in(); #1;
    chk("halt_T1_ctl", 32'(ctl), 32'(C_DRAIN));
    tick();
    chk("halt_T2_ctl", 32'(ctl), 32'(C_DRAIN));
    tick();
    chk("halt_T3_ctl", 32'(ctl), 32'(C_HALTED));
    chk("halt_no_extra_flush", 32'(flush_cnt), 32'd1);
    ex_branch_taken = 1'b1; ex_halt = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; #1;
    chk("halted_ignores_ctl", 32'(ctl), 32'(C_HALTED));
    tick();
    chk("halted_T4_ctl", 32'(ctl), 32'(C_HALTED));
    chk("halted_ign_flush", 32'(flush_cnt), 32'd1);
    chk("halted_ign_stall", 32'(stall_cnt), 32'd2);
    tick();
    clear_in(); resume = 1'b1; #1;
    chk("halted_T5_ctl", 32'(ctl), 32'(C_HALTED));
    tick();
    resume = 1'b0; #1;
    chk("resume_T6_ctl", 32'(ctl), 32'(C_NORMAL));

    // halt at T with mem_busy during T+1..T+3
    ex_halt = 1'b1; #1;
    chk("hb_T_ctl", 32'(ctl), 32'(C_HALT));
    for (int c = 1; c <= 6; c++) begin
      tick();
      clear_in();
      mem_busy = (c >= 1 && c <= 3);
      #1;
      if (c <= 3)      chk($sformatf("hb_T%0d_ctl", c), 32'(ctl), 32'(C_DRBUSY));
      else if (c <= 5) chk($sformatf("hb_T%0d_ctl", c), 32'(ctl), 32'(C_DRAIN));
      else             chk($sformatf("hb_T%0d_ctl", c), 32'(ctl), 32'(C_HALTED));
    end
    resume = 1'b1;
    tick();
    clear_in(); #1;
    chk("resume2_ctl", 32'(ctl), 32'(C_NORMAL));

    // drive stall_cnt into saturation
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    for (int i = 0; i < 65536 + 3; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    tick();
    chk("sat_hold_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);

    // reset asserted mid-DRAIN
    clear_in(); ex_halt = 1'b1;
    tick();
    clear_in(); #1;
    chk("pre_rst_drain_ctl", 32'(ctl), 32'(C_DRAIN));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_mid_stall", 32'(stall_cnt), 32'd0);
    chk("rst_mid_flush", 32'(flush_cnt), 32'd0);
    tick();
    chk("rst_hold_ctl", 32'(ctl), 32'(C_IDLE));
    rst_n = 1'b1; #1;
    chk("post_rst_ctl", 32'(ctl), 32'(C_NORMAL));
    tick();
    chk("post_rst_edge_ctl", 32'(ctl), 32'(C_NORMAL));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
